// File: rtl/temp_sample_ram_if.sv
// Request/response bundle for temp_sample_ram: write, clear, read ports
// plus sweep status and error strobe.
interface temp_sample_ram_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_all;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              busy;
   logic              err;

   modport master (
      output wr_en, wr_addr, wr_data,
      output clr_en, clr_addr, clr_all,
      output rd_en, rd_addr,
      input  rd_data, rd_valid, busy, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  clr_en, clr_addr, clr_all,
      input  rd_en, rd_addr,
      output rd_data, rd_valid, busy, err
   );
endinterface

// File: rtl/temp_sample_ram.sv
// Sample memory: write + clear ports, registered read, clear-all sweep.
// Define RAM_WR_FWD_EN for write-to-read forwarding (default read-first).
module temp_sample_ram #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   temp_sample_ram_if.slave bus
);

   typedef enum logic {
      IDLE,
      SWEEP
   } state_e;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              sweep;
   logic              wr_in, clr_in, rd_in;
   logic              wr_ok, clr_ok;
   logic [DATA_W-1:0] rd_word;

   always_comb begin
      sweep  = (state_q == SWEEP);
      wr_in  = {1'b0, bus.wr_addr}  < DEPTH_C;
      clr_in = {1'b0, bus.clr_addr} < DEPTH_C;
      rd_in  = {1'b0, bus.rd_addr}  < DEPTH_C;
      wr_ok  = bus.wr_en  && wr_in  && !sweep;
      clr_ok = bus.clr_en && clr_in && !sweep;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.clr_all) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end
         end
         SWEEP: begin
            if (ptr_q == LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = SWEEP;
            ptr_d   = '0;
         end
      endcase
   end

`ifdef RAM_WR_FWD_EN
   // Same-edge write beats same-edge clear, matching the array priority.
   always_comb begin
      rd_word = mem_q[bus.rd_addr];
      if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
         rd_word = bus.wr_data;
      end else if (clr_ok && (bus.clr_addr == bus.rd_addr)) begin
         rd_word = '0;
      end
   end
`else
   always_comb begin
      rd_word = mem_q[bus.rd_addr];
   end
`endif

   always_comb begin
      rd_valid_d = bus.rd_en && rd_in;
      rd_data_d  = rd_data_q;
      if (rd_valid_d) begin
         rd_data_d = rd_word;
      end
      // Dropped clears during a sweep stay silent; dropped writes do not.
      err_d = (bus.wr_en  && (!wr_in || sweep))
            || (bus.clr_en && !clr_in)
            || (bus.rd_en  && !rd_in);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= SWEEP;
         ptr_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   // Later assignments win: write overrides a same-address clear.
   always_ff @(posedge clk) begin
      if (sweep) begin
         mem_q[ptr_q] <= '0;
      end
      if (clr_ok) begin
         mem_q[bus.clr_addr] <= '0;
      end
      if (wr_ok) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = sweep;
   assign bus.err      = err_q;

endmodule
